// File: rtl/inexrecur_frame_writer.sv
// Serialises accepted recursion frames into sequential 32-bit store writes, dropping empty intervals.
// Optional check word after each frame when INEXRECUR_PARITY_EN is defined (FW becomes 4).
module inexrecur_frame_writer #(
    parameter int DEPTH = 4096,
    parameter int ZW    = 6,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    frm_op,
    input  logic [ZW-1:0] frm_z,
    input  logic [IW-1:0] frm_i,
    input  logic [31:0]   frm_k,
    input  logic [31:0]   frm_l,
    output logic          we,
    output logic [31:0]   w_data,
    output logic [12:0]   words_used,
    output logic [11:0]   frame_cnt,
    output logic [7:0]    drop_cnt,
    output logic          full,
    output logic          busy
);

`ifdef INEXRECUR_PARITY_EN
    localparam int FW = 4;
    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;
`else
    localparam int FW = 3;
    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] k_q, k_d;
    logic [31:0] l_q, l_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [12:0] words_q, words_d;
    logic [11:0] frame_q, frame_d;
    logic [7:0]  drop_q, drop_d;
`ifdef INEXRECUR_PARITY_EN
    logic [31:0] hdr_q, hdr_d;
`endif

    logic [5:0]  z6;
    logic [11:0] i12;
    logic [31:0] hdr_w;
    logic        full_w;
    logic        accept;

    assign z6     = 6'(frm_z);
    assign i12    = 12'(frm_i);
    assign hdr_w  = {frm_op, z6, i12, frame_q};
    assign full_w = (DEPTH - int'({19'b0, words_q})) < FW;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        l_d     = l_q;
        we_d    = 1'b0;
        wdata_d = '0;
        frame_d = frame_q;
        drop_d  = drop_q;
        // we_q is one cycle behind we_d, so a word is counted the cycle after it is driven
        words_d = words_q + {12'b0, we_q};
`ifdef INEXRECUR_PARITY_EN
        hdr_d   = hdr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (frm_k > frm_l) begin
                        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                    end else begin
                        k_d     = frm_k;
                        l_d     = frm_l;
`ifdef INEXRECUR_PARITY_EN
                        hdr_d   = hdr_w;
`endif
                        state_d = W0;
                        we_d    = 1'b1;
                        wdata_d = hdr_w;
                    end
                end
            end
            W0: begin
                state_d = W1;
                we_d    = 1'b1;
                wdata_d = k_q;
            end
            W1: begin
                state_d = W2;
                we_d    = 1'b1;
                wdata_d = l_q;
            end
`ifdef INEXRECUR_PARITY_EN
            W2: begin
                state_d = W3;
                we_d    = 1'b1;
                wdata_d = hdr_q ^ k_q ^ l_q;
            end
            W3: begin
                state_d = IDLE;
                frame_d = frame_q + 12'd1;
            end
`else
            W2: begin
                state_d = IDLE;
                frame_d = frame_q + 12'd1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            l_q     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            words_q <= '0;
            frame_q <= '0;
            drop_q  <= '0;
`ifdef INEXRECUR_PARITY_EN
            hdr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            l_q     <= l_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
`ifdef INEXRECUR_PARITY_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE) && !full_w;
    assign we         = we_q;
    assign w_data     = wdata_q;
    assign words_used = words_q;
    assign frame_cnt  = frame_q;
    assign drop_cnt   = drop_q;
    assign full       = full_w;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_inexrecur_frame_writer.sv
// Directed self-checking bench for inexrecur_frame_writer; also builds with INEXRECUR_PARITY_EN.
module tb_inexrecur_frame_writer;

`ifdef INEXRECUR_PARITY_EN
    localparam int FW = 4;
`else
    localparam int FW = 3;
`endif
    localparam int DEPTH = 4096;
    localparam int FR    = DEPTH / FW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  frm_op;
    logic [5:0]  frm_z;
    logic [11:0] frm_i;
    logic [31:0] frm_k;
    logic [31:0] frm_l;
    logic        we;
    logic [31:0] w_data;
    logic [12:0] words_used;
    logic [11:0] frame_cnt;
    logic [7:0]  drop_cnt;
    logic        full;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    inexrecur_frame_writer #(.DEPTH(DEPTH), .ZW(6), .IW(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .frm_op(frm_op), .frm_z(frm_z), .frm_i(frm_i), .frm_k(frm_k), .frm_l(frm_l),
        .we(we), .w_data(w_data), .words_used(words_used), .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr_of(input logic [1:0] op, input logic [5:0] z,
                                           input logic [11:0] i, input logic [11:0] fc);
        return {op, z, i, fc};
    endfunction

    // Called at a negedge; returns at the negedge on which the last word was sampled.
    task automatic send_frame(input logic [1:0] op, input logic [5:0] z, input logic [11:0] i,
                              input logic [31:0] k, input logic [31:0] l,
                              output logic [31:0] w0, output logic [31:0] w1,
                              output logic [31:0] w2, output logic [31:0] w3, output logic ok);
        int wait_n;
        wait_n = 0;
        ok = 1'b1;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        frm_op = op; frm_z = z; frm_i = i; frm_k = k; frm_l = l;
        in_valid = 1'b1;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ok = ok & we; w0 = w_data;
        @(negedge clk);
        ok = ok & we; w1 = w_data;
        @(negedge clk);
        ok = ok & we; w2 = w_data;
        if (FW == 4) begin
            @(negedge clk);
            ok = ok & we; w3 = w_data;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w0, w1, w2, w3;
        logic        ok;
        logic [19:0] vec, expv;
        int          wecnt, viol, hs, nf, badh;
        logic [31:0] nv, last_hdr;

        rst_n = 1'b0; in_valid = 1'b0;
        frm_op = '0; frm_z = '0; frm_i = '0; frm_k = '0; frm_l = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_words", words_used, 0);
        chk("rst_frames", frame_cnt, 0);
        chk("rst_drops", drop_cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);

        // basic frame
        send_frame(2'd1, 6'd2, 12'd5, 32'd10, 32'd20, w0, w1, w2, w3, ok);
        chk("f1_we", ok, 1);
        chk("f1_hdr", w0, 32'h4200_5000);
        chk("f1_k", w1, 32'd10);
        chk("f1_l", w2, 32'd20);
`ifdef INEXRECUR_PARITY_EN
        chk("f1_par", w3, 32'h4200_501E);
`endif
        @(negedge clk);
        chk("f1_we_off", we, 0);
        chk("f1_wdata_off", w_data, 0);
        chk("f1_ready", in_ready, 1);
        chk("f1_frames", frame_cnt, 1);
        chk("f1_words", words_used, FW);

        // empty-interval drop, then saturation
        frm_k = 32'd30; frm_l = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("drop_we", we, 0);
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_ready", in_ready, 1);
        chk("drop_words", words_used, FW);
        wecnt = 0;
        in_valid = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (we) wecnt++;
        end
        in_valid = 1'b0;
        chk("drop_sat", drop_cnt, 255);
        chk("drop_no_we", wecnt, 0);

        // continuous in_valid
        frm_op = 2'd2; frm_z = 6'd0; frm_i = 12'd7; frm_k = 32'd100; frm_l = 32'd200;
        in_valid = 1'b1;
        vec = '0; expv = '0; viol = 0; hs = 0;
        for (int j = 0; j < 20; j++) begin
            vec[j]  = we;
            expv[j] = (j % (FW + 1)) != 0;
            if (in_ready && busy) viol++;
            if (in_ready) hs++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        nf = (20 + FW) / (FW + 1);
        chk("cont_we_pattern", vec, expv);
        chk("cont_ready_busy", viol, 0);
        chk("cont_handshakes", hs, nf);
        @(negedge clk);
        chk("cont_frames", frame_cnt, 1 + nf);
        chk("cont_words", words_used, FW * (1 + nf));

        // reset during W1
        frm_op = 2'd0; frm_z = 6'd1; frm_i = 12'd1; frm_k = 32'd1; frm_l = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_we_before", we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_we", we, 0);
        chk("mid_wdata", w_data, 0);
        chk("mid_words", words_used, 0);
        chk("mid_frames", frame_cnt, 0);
        chk("mid_drops", drop_cnt, 0);
        chk("mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(2'd3, 6'd63, 12'hABC, 32'd5, 32'd5, w0, w1, w2, w3, ok);
        chk("post_we", ok, 1);
        chk("post_hdr", w0, 32'hFFAB_C000);
        chk("post_k", w1, 32'd5);
        chk("post_l", w2, 32'd5);
`ifdef INEXRECUR_PARITY_EN
        chk("post_par", w3, 32'hFFAB_C000);
`endif

        // fill the store
        badh = 0;
        last_hdr = '0;
        for (int n = 1; n < FR; n++) begin
            nv = n;
            send_frame(nv[1:0], nv[5:0], nv[11:0], nv, nv + 32'd1, w0, w1, w2, w3, ok);
            if (!ok || w0 !== hdr_of(nv[1:0], nv[5:0], nv[11:0], nv[11:0]) ||
                w1 !== nv || w2 !== nv + 32'd1) badh++;
            if (FW == 4 && w3 !== (w0 ^ nv ^ (nv + 32'd1))) badh++;
            last_hdr = w0;
        end
        chk("fill_frames_ok", badh, 0);
        chk("fill_last_fc", last_hdr[11:0], FR - 1);
        @(negedge clk);
        chk("fill_words", words_used, FR * FW);
        chk("fill_full", full, 1);
        chk("fill_ready", in_ready, 0);
        chk("fill_frames", frame_cnt, FR);

        // stalled while full, including empty intervals
        wecnt = 0;
        frm_k = 32'd1; frm_l = 32'd2; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (we) wecnt++;
        end
        frm_k = 32'd9; frm_l = 32'd2;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("stall_no_we", wecnt, 0);
        chk("stall_words", words_used, FR * FW);
        chk("stall_drops", drop_cnt, 0);
        chk("stall_frames", frame_cnt, FR);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
